// File: rtl/mmu_pkg.sv
// Shared types, default widths and helpers for the systolic MMU feeder and host paths.
package mmu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    OUT
  } feeder_state_t;

  localparam int MMU_DATA_W = 8;
  localparam int MMU_ACC_W  = 16;

  // Clamp a signed value into the signed range of a data_w-bit word (data_w <= 32).
  function automatic logic [31:0] saturate(input logic signed [63:0] val, input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (val > hi) return hi[31:0];
    if (val < lo) return lo[31:0];
    return val[31:0];
  endfunction

endpackage

// File: rtl/mmu_feed_skew.sv
// Turns a latched N x N matrix into N diagonally skewed lanes for one feed step.
// col_sel=0: lane i = M[i][step-i] (row edge); col_sel=1: lane j = M[step-j][j] (column edge).
module mmu_feed_skew import mmu_pkg::*; #(
  parameter int N      = 2,
  parameter int DATA_W = MMU_DATA_W,
  parameter int STEP_W = 3
) (
  input  logic [N*N*DATA_W-1:0] mat,
  input  logic [STEP_W-1:0]     step,
  input  logic                  col_sel,
  input  logic                  en,
  output logic [N*DATA_W-1:0]   lanes
);

  always_comb begin
    lanes = '0;
    for (int l = 0; l < N; l++) begin
      if (en && (int'(step) - l) >= 0 && (int'(step) - l) < N) begin
        if (col_sel)
          lanes[l*DATA_W +: DATA_W] = mat[((int'(step) - l)*N + l)*DATA_W +: DATA_W];
        else
          lanes[l*DATA_W +: DATA_W] = mat[(l*N + (int'(step) - l))*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mmu_feeder_n.sv
// Feeder and result drainer for the output-stationary N x N systolic MMU.
// Define MMU_FEEDER_SAT_EN to saturate result words instead of truncating them.
module mmu_feeder_n import mmu_pkg::*; #(
  parameter int N         = 2,
  parameter int DATA_W    = MMU_DATA_W,
  parameter int ACC_W     = MMU_ACC_W,
  parameter int EXTRA_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     ready,
  input  logic [N*N*DATA_W-1:0]    weights,
  input  logic [N*N*DATA_W-1:0]    inputs,
  input  logic [N*N*ACC_W-1:0]     c_out,
  output logic                     clear,
  output logic [N*DATA_W-1:0]      a_data,
  output logic [N*DATA_W-1:0]      b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(N*N)-1:0]   out_idx,
  output logic                     out_last
);

  localparam int NN        = N * N;
  localparam int IDX_W     = $clog2(NN);
  localparam int FEED_LEN  = 2 * N - 1;
  localparam int DRAIN_LEN = N + EXTRA_LAT;
  localparam int CNT_W     = $clog2(2 * N + EXTRA_LAT + 1);

  feeder_state_t state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NN*DATA_W-1:0]   w_q, w_d, x_q, x_d;
  logic [NN*ACC_W-1:0]    res_q, res_d;
  logic                   ready_q, ready_d;
  logic                   clear_q, clear_d;
  logic [N*DATA_W-1:0]    a_q, a_d, b_q, b_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;

  logic                   accept;
  logic                   handshake;
  logic                   present;
  logic                   feed_en;
  logic [IDX_W-1:0]       next_idx;
  logic [ACC_W-1:0]       cur_word;
  logic [DATA_W-1:0]      conv_word;

  assign accept    = (state_q == IDLE) && ready_q && start;
  assign handshake = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        if (cnt_q == CNT_W'(FEED_LEN - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
          state_d = OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUT:     if (handshake && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    feed_en     = (state_d == FEED);
    ready_d     = (state_d == IDLE);
    clear_d     = (state_d != FEED) && (state_d != DRAIN);
    present     = (state_q == OUT) && !(handshake && out_last_q);
    next_idx    = handshake ? out_idx_q + IDX_W'(1) : out_idx_q;
    cur_word    = res_q[next_idx*ACC_W +: ACC_W];
    out_valid_d = present;
    out_idx_d   = present ? next_idx : '0;
    out_last_d  = present && (next_idx == IDX_W'(NN - 1));
    out_data_d  = present ? conv_word : '0;
  end

`ifdef MMU_FEEDER_SAT_EN
  assign conv_word = DATA_W'(saturate(64'(signed'(cur_word)), DATA_W));
`else
  logic unused_hi;
  assign conv_word = cur_word[DATA_W-1:0];
  assign unused_hi = ^cur_word[ACC_W-1:DATA_W];
`endif

  always_comb begin
    w_d   = accept ? weights : w_q;
    x_d   = accept ? inputs  : x_q;
    res_d = (state_q == DRAIN && cnt_q == CNT_W'(DRAIN_LEN - 1)) ? c_out : res_q;
  end

  mmu_feed_skew #(.N(N), .DATA_W(DATA_W), .STEP_W(CNT_W)) u_skew_a (
    .mat     (w_q),
    .step    (cnt_d),
    .col_sel (1'b0),
    .en      (feed_en),
    .lanes   (a_d)
  );

  mmu_feed_skew #(.N(N), .DATA_W(DATA_W), .STEP_W(CNT_W)) u_skew_b (
    .mat     (x_q),
    .step    (cnt_d),
    .col_sel (1'b1),
    .en      (feed_en),
    .lanes   (b_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      clear_q     <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      w_q         <= '0;
      x_q         <= '0;
      res_q       <= '0;
    end else begin
      ready_q     <= ready_d;
      clear_q     <= clear_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      w_q         <= w_d;
      x_q         <= x_d;
      res_q       <= res_d;
    end
  end

  assign ready     = ready_q;
  assign clear     = clear_q;
  assign a_data    = a_q;
  assign b_data    = b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule
